mcl65_bus_bridge: RTL and testbench
===================================

Name: mcl65_bus_bridge

Overview:
- Sits directly downstream of the MCL65 6502 bus pins and turns its asynchronous-style 6502 bus into a synchronous req/ack memory port.
- Generates the CLK0 phase clock that the core consumes.
- Sequences the core's RESET_n.
- Returns read data onto the core's data bus, stretching phase 2 when memory is slow.

Parameters:
- HALF_PERIOD, 25: CORE_CLK cycles per CLK0 phase; 1 MHz CLK0 at 50 MHz. Legal range 12..255.
- SAMPLE_OFFSET, 8: CORE_CLK cycles into phase 2 before the bus is sampled. Covers the core's I/O pipeline. Must be ≥ 6 and < HALF_PERIOD.
- DATA_HOLD, 5: CORE_CLK cycles read data stays driven after CLK0 falls. Must be < HALF_PERIOD.
- RESET_HOLD, 16: CLK0 rising edges CPU_RESET_n stays low after RESET deasserts.

Ports:
- CORE_CLK  in  1  sole clock
- RESET  in  1  asynchronous, active-high reset
- CLK0  out  1  phase clock to core: low = phase 1, high = phase 2
- CPU_RESET_n  out  1  reset to core
- CPU_A  in  16  core address
- CPU_RDWR_n  in  1  core read/write strobe
- CPU_SYNC  in  1  core opcode-fetch flag
- CPU_D_OUT  in  8  core write data (core D when DIR0=1)
- CPU_D_IN  out  8  read data to core D
- CPU_D_OE  out  1  bridge drives core D; top level tri-states D with it
- MEM_REQ  out  1  request, level
- MEM_WE  out  1  1 = write
- MEM_FETCH  out  1  registered CPU_SYNC
- MEM_ADDR  out  16  request address
- MEM_WDATA  out  8  write data
- MEM_RDATA  in  8  read data, valid with MEM_ACK
- MEM_ACK  in  1  one-cycle completion pulse

Behaviour:
Reset values (RESET high, async):
- CLK0=0, CPU_RESET_n=0, CPU_D_OE=0, CPU_D_IN=0, MEM_REQ=0, MEM_WE=0, MEM_FETCH=0, MEM_ADDR=0, MEM_WDATA=0.
- All counters 0; state IDLE.
- Reset mid-request drops MEM_REQ immediately. Memory must tolerate an abandoned request.

Phase generator:
- Counter runs 0..HALF_PERIOD-1. CLK0 toggles on the cycle after the terminal count.
- Stretch: counter freezes at terminal count while phase 2 is active and state is REQ. CLK0 stays high until ack.

Reset sequencer:
- Counts CLK0 rising edges after RESET is low. CPU_RESET_n rises on the CORE_CLK after the RESET_HOLD-th edge.
- No bus requests are issued while CPU_RESET_n=0.

FSM (state enum in package):
- IDLE: waiting for phase 2. On the CLK0 rising edge → WAIT.
- WAIT: when phase-2 count == SAMPLE_OFFSET:
  - latch MEM_ADDR=CPU_A, MEM_WE=~CPU_RDWR_n, MEM_FETCH=CPU_SYNC, MEM_WDATA=CPU_D_OUT;
  - assert MEM_REQ;
  - → REQ.
- REQ: MEM_REQ and all MEM_* outputs stable until MEM_ACK.
  - On ack: MEM_REQ=0 next cycle.
  - Reads: CPU_D_IN=MEM_RDATA, CPU_D_OE=1.
  - → DONE.
  - Ack may arrive on the first REQ cycle (minimum latency 1).
- DONE: release the stretch; phase 2 completes its remaining count, or ends next cycle if it was stretched.
  - After CLK0 falls, CPU_D_OE stays 1 for DATA_HOLD cycles, then 0.
  - → IDLE.
  - CPU_D_IN holds its value until the next read.

Edge rules:
- MEM_ACK outside REQ is ignored.
- Exactly one request per CLK0 cycle, reads and writes alike. The core always performs a bus cycle.
- CPU_D_OE is never 1 during a write cycle.

Decomposition:
- Package mcl65_bus_pkg holds:
  - state enum {IDLE, WAIT, REQ, DONE};
  - ADDR_W=16, DATA_W=8;
  - phase-counter width function.
- Sub-module mcl65_phase_gen owns the CLK0 counter, the stretch input, and the rise/fall/phase-2-count outputs.
- The bridge FSM and reset sequencer stay in the top module.

Test Plan (defaults unless noted):
- Reset release: RESET 1→0 → CLK0 period 50 CORE_CLK; CPU_RESET_n rises after the 16th CLK0 rise; MEM_REQ stays 0 before that.
- Zero-wait read:
  - stimulus: CPU_A=FFFC, RDWR_n=1, SYNC=0; ack 1 cycle after req with MEM_RDATA=0x4C;
  - response: MEM_REQ at phase-2 count 8, MEM_WE=0; CPU_D_OE=1 with CPU_D_IN=0x4C until 5 cycles after CLK0 falls; phase 2 = 25 cycles.
- Write:
  - stimulus: CPU_A=0x0200, RDWR_n=0, CPU_D_OUT=0xA5; ack after 3 cycles;
  - response: MEM_WE=1, MEM_WDATA=0xA5, MEM_ADDR=0x0200; CPU_D_OE never 1.
- Slow memory: ack 40 cycles after req → CLK0 high for 8+40+1 cycles; no second request; D valid before CLK0 falls.
- Opcode fetch: CPU_SYNC=1 → MEM_FETCH=1 for that request only.
- Reset mid-REQ: assert RESET while MEM_REQ=1 → MEM_REQ, CLK0, CPU_RESET_n and CPU_D_OE low in the same cycle; a later ack is ignored.

Source files
------------

// File: rtl/mcl65_bus_pkg.sv
// Shared types and widths for the MCL65 6502 bus bridge.
package mcl65_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ,
    DONE
  } state_e;

  // Bits needed to count 0..half_period-1.
  function automatic int unsigned phase_cnt_w(input int unsigned half_period);
    return (half_period < 2) ? 1 : $clog2(half_period);
  endfunction

endpackage

// File: rtl/mcl65_phase_gen.sv
// CLK0 phase generator: HALF_PERIOD core clocks per phase, phase 2 can be
// stretched at its terminal count while the bridge waits on memory.
module mcl65_phase_gen
  import mcl65_bus_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 25,
  localparam int unsigned CW = phase_cnt_w(HALF_PERIOD)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stretch_i,
  output logic          clk0_o,
  output logic          rise_o,
  output logic          fall_o,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] TERM = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk0_q, clk0_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // rise/fall are high during the first core cycle of the new phase.
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    clk0_d = clk0_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (cnt_q == TERM) begin
      if (clk0_q && stretch_i) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d  = '0;
        clk0_d = ~clk0_q;
        rise_d = ~clk0_q;
        fall_d = clk0_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      clk0_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk0_q <= clk0_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign clk0_o = clk0_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/mcl65_bus_bridge.sv
// Bridges the MCL65 6502-style bus to a synchronous req/ack memory port,
// generating CLK0, sequencing core reset and returning read data.
module mcl65_bus_bridge
  import mcl65_bus_pkg::*;
#(
  parameter int unsigned HALF_PERIOD   = 25,
  parameter int unsigned SAMPLE_OFFSET = 8,
  parameter int unsigned DATA_HOLD     = 5,
  parameter int unsigned RESET_HOLD    = 16
) (
  input  logic              CORE_CLK,
  input  logic              RESET,
  output logic              CLK0,
  output logic              CPU_RESET_n,
  input  logic [ADDR_W-1:0] CPU_A,
  input  logic              CPU_RDWR_n,
  input  logic              CPU_SYNC,
  input  logic [DATA_W-1:0] CPU_D_OUT,
  output logic [DATA_W-1:0] CPU_D_IN,
  output logic              CPU_D_OE,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic              MEM_FETCH,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK
);

  localparam int unsigned CW = phase_cnt_w(HALF_PERIOD);
  localparam int unsigned RW = $clog2(RESET_HOLD + 1);
  // Registered request becomes visible exactly when the phase-2 count reads SAMPLE_OFFSET.
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_OFFSET - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(DATA_HOLD - 1);
  localparam logic [RW-1:0] RESET_LAST = RW'(RESET_HOLD - 1);

  state_e            state_q;
  logic [RW-1:0]     rst_cnt_q;
  logic              cpu_reset_n_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              mem_fetch_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] d_in_q;
  logic              d_oe_q;
  logic [CW-1:0]     hold_q;

  logic          clk0;
  logic          rise;
  logic          fall;
  logic [CW-1:0] cnt;
  logic          stretch;

  assign stretch = (state_q == REQ);

  mcl65_phase_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_phase_gen (
    .clk_i    (CORE_CLK),
    .rst_i    (RESET),
    .stretch_i(stretch),
    .clk0_o   (clk0),
    .rise_o   (rise),
    .fall_o   (fall),
    .cnt_o    (cnt)
  );

  always_ff @(posedge CORE_CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      rst_cnt_q     <= '0;
      cpu_reset_n_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_fetch_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      d_in_q        <= '0;
      d_oe_q        <= 1'b0;
      hold_q        <= '0;
    end else begin
      // Core reset release counts CLK0 rising edges.
      if (!cpu_reset_n_q && rise) begin
        rst_cnt_q <= rst_cnt_q + RW'(1);
        if (rst_cnt_q == RESET_LAST) begin
          cpu_reset_n_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (rise && cpu_reset_n_q) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (clk0 && cnt == SAMPLE_CNT) begin
            mem_addr_q  <= CPU_A;
            mem_we_q    <= ~CPU_RDWR_n;
            mem_fetch_q <= CPU_SYNC;
            mem_wdata_q <= CPU_D_OUT;
            mem_req_q   <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (MEM_ACK) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              d_in_q <= MEM_RDATA;
              d_oe_q <= 1'b1;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          // Keep driving read data for DATA_HOLD cycles once CLK0 has fallen.
          if (fall || hold_q != '0) begin
            if (hold_q == HOLD_LAST) begin
              hold_q  <= '0;
              d_oe_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              hold_q <= hold_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CLK0        = clk0;
  assign CPU_RESET_n = cpu_reset_n_q;
  assign CPU_D_IN    = d_in_q;
  assign CPU_D_OE    = d_oe_q;
  assign MEM_REQ     = mem_req_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_FETCH   = mem_fetch_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;

endmodule

// File: tb/tb_mcl65_bus_bridge.sv
// Scoreboard bench for mcl65_bus_bridge: directed bus cycles, memory responder,
// and a monitor comparing each request and phase-2 response against expectations.
module tb_mcl65_bus_bridge;

  localparam int SAMPLE    = 8;
  localparam int HOLD      = 5;
  localparam int NVEC      = 7;

  logic        CORE_CLK = 1'b0;
  logic        RESET;
  logic        CLK0;
  logic        CPU_RESET_n;
  logic [15:0] CPU_A;
  logic        CPU_RDWR_n;
  logic        CPU_SYNC;
  logic [7:0]  CPU_D_OUT;
  logic [7:0]  CPU_D_IN;
  logic        CPU_D_OE;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic        MEM_FETCH;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;
  logic        MEM_ACK;

  mcl65_bus_bridge dut (
    .CORE_CLK   (CORE_CLK),
    .RESET      (RESET),
    .CLK0       (CLK0),
    .CPU_RESET_n(CPU_RESET_n),
    .CPU_A      (CPU_A),
    .CPU_RDWR_n (CPU_RDWR_n),
    .CPU_SYNC   (CPU_SYNC),
    .CPU_D_OUT  (CPU_D_OUT),
    .CPU_D_IN   (CPU_D_IN),
    .CPU_D_OE   (CPU_D_OE),
    .MEM_REQ    (MEM_REQ),
    .MEM_WE     (MEM_WE),
    .MEM_FETCH  (MEM_FETCH),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_RDATA  (MEM_RDATA),
    .MEM_ACK    (MEM_ACK)
  );

  always #5 CORE_CLK = ~CORE_CLK;

  // hi = expected CLK0 high cycles; lat = REQ cycle on which ack arrives.
  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic        fetch;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          lat;
    int          hi;
    bit          stray;
  } vec_t;

  vec_t vecs [NVEC];
  vec_t exp_q[$];
  vec_t resp_q[$];

  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;
  bit prev_clk0 = 1'b0;
  bit prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic wait_fall(input int budget);
    bit hi_seen;
    bit done;
    hi_seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CORE_CLK);
      if (CLK0) hi_seen = 1'b1;
      else if (hi_seen) done = 1'b1;
    end
    chk("clk0_fall_seen", 32'(done), 32'd1);
  endtask

  // Memory responder: acks the lat-th REQ cycle, optionally with a stray late ack.
  initial begin : memory
    vec_t r;
    MEM_ACK = 1'b0;
    MEM_RDATA = 8'h00;
    forever begin
      @(negedge CORE_CLK);
      if (MEM_REQ === 1'b1 && resp_q.size() != 0) begin
        r = resp_q.pop_front();
        repeat (r.lat - 1) @(negedge CORE_CLK);
        MEM_ACK = 1'b1;
        MEM_RDATA = r.rdata;
        @(negedge CORE_CLK);
        MEM_ACK = 1'b0;
        MEM_RDATA = 8'h00;
        if (r.stray) begin
          repeat (2) @(negedge CORE_CLK);
          MEM_ACK = 1'b1;
          MEM_RDATA = 8'hEE;
          @(negedge CORE_CLK);
          MEM_ACK = 1'b0;
          MEM_RDATA = 8'h00;
        end
      end
    end
  end

  // Monitor: pops on each new request, checks phase 2 and the data hold window.
  initial begin : monitor
    vec_t cur;
    int hi_cnt, lo_idx, n_req, oe_hi, oe_lo, req_len;
    bit have_cur, hold_act, last_oe, unstable;
    logic [7:0] last_din, last_rd;
    hi_cnt = 0; lo_idx = 0; n_req = 0; oe_hi = 0; oe_lo = 0; req_len = 0;
    have_cur = 1'b0; hold_act = 1'b0; last_oe = 1'b0; unstable = 1'b0;
    last_din = 8'h00; last_rd = 8'h00;
    cur = '{addr: 16'h0, we: 1'b0, fetch: 1'b0, wdata: 8'h0, rdata: 8'h0, lat: 0, hi: 0, stray: 1'b0};
    forever begin
      @(negedge CORE_CLK);
      if (mon_en) begin
        if (CLK0) begin
          if (!prev_clk0) begin
            hi_cnt = 0; n_req = 0; oe_hi = 0;
          end
          if (MEM_REQ && !prev_req) begin
            n_req++;
            chk("req_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              have_cur = 1'b1;
              req_len = 0;
              unstable = 1'b0;
              chk("req_addr", 32'(MEM_ADDR), 32'(cur.addr));
              chk("req_we", 32'(MEM_WE), 32'(cur.we));
              chk("req_fetch", 32'(MEM_FETCH), 32'(cur.fetch));
              chk("req_wdata", 32'(MEM_WDATA), 32'(cur.wdata));
              chk("req_phase2_count", 32'(hi_cnt), 32'(SAMPLE));
            end
          end
          if (CPU_D_OE) oe_hi++;
          last_oe = CPU_D_OE;
          last_din = CPU_D_IN;
          hi_cnt++;
        end else begin
          if (prev_clk0 && have_cur) begin
            chk("phase2_len", 32'(hi_cnt), 32'(cur.hi));
            chk("req_per_cycle", 32'(n_req), 32'd1);
            if (cur.we) begin
              chk("wr_oe_phase2", 32'(oe_hi), 32'd0);
              chk("d_in_kept", 32'(last_din), 32'(last_rd));
            end else begin
              chk("rd_oe_before_fall", 32'(last_oe), 32'd1);
              chk("rd_data", 32'(last_din), 32'(cur.rdata));
              last_rd = cur.rdata;
            end
            hold_act = 1'b1;
            lo_idx = 0;
            oe_lo = 0;
          end
          if (hold_act) begin
            if (CPU_D_OE) oe_lo++;
            lo_idx++;
            if (lo_idx == 10) begin
              chk("oe_hold_cycles", 32'(oe_lo), cur.we ? 32'd0 : 32'(HOLD));
              hold_act = 1'b0;
            end
          end
        end
        if (MEM_REQ) begin
          req_len++;
          if (MEM_ADDR !== cur.addr || MEM_WE !== cur.we || MEM_FETCH !== cur.fetch ||
              MEM_WDATA !== cur.wdata) unstable = 1'b1;
        end
        if (!MEM_REQ && prev_req && have_cur) begin
          chk("req_len", 32'(req_len), 32'(cur.lat));
          chk("req_stable", 32'(unstable), 32'd0);
        end
        prev_clk0 = CLK0;
        prev_req = MEM_REQ;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int t, rises, r1, r2, last_rise, req_early, req_hi, oe_on;
    bit pc, got, seen;
    vecs[0] = '{addr: 16'hFFFC, we: 1'b0, fetch: 1'b0, wdata: 8'h11, rdata: 8'h4C, lat: 1,  hi: 25, stray: 1'b0};
    vecs[1] = '{addr: 16'h0200, we: 1'b1, fetch: 1'b0, wdata: 8'hA5, rdata: 8'h00, lat: 3,  hi: 25, stray: 1'b1};
    vecs[2] = '{addr: 16'h1234, we: 1'b0, fetch: 1'b0, wdata: 8'h22, rdata: 8'h3C, lat: 40, hi: 49, stray: 1'b0};
    vecs[3] = '{addr: 16'h8000, we: 1'b0, fetch: 1'b1, wdata: 8'h33, rdata: 8'hA9, lat: 2,  hi: 25, stray: 1'b0};
    vecs[4] = '{addr: 16'h8001, we: 1'b0, fetch: 1'b0, wdata: 8'h44, rdata: 8'h7E, lat: 17, hi: 26, stray: 1'b0};
    vecs[5] = '{addr: 16'h01FF, we: 1'b1, fetch: 1'b0, wdata: 8'h5A, rdata: 8'h00, lat: 16, hi: 25, stray: 1'b0};
    vecs[6] = '{addr: 16'hABCD, we: 1'b0, fetch: 1'b0, wdata: 8'h66, rdata: 8'h99, lat: 30, hi: 0,  stray: 1'b0};

    RESET = 1'b1;
    CPU_A = 16'h0000;
    CPU_RDWR_n = 1'b1;
    CPU_SYNC = 1'b0;
    CPU_D_OUT = 8'h00;
    repeat (3) @(negedge CORE_CLK);
    chk("rst_clk0", 32'(CLK0), 32'd0);
    chk("rst_cpu_reset_n", 32'(CPU_RESET_n), 32'd0);
    chk("rst_d_oe", 32'(CPU_D_OE), 32'd0);
    chk("rst_d_in", 32'(CPU_D_IN), 32'd0);
    chk("rst_mem_req", 32'(MEM_REQ), 32'd0);
    chk("rst_mem_we", 32'(MEM_WE), 32'd0);
    chk("rst_mem_fetch", 32'(MEM_FETCH), 32'd0);
    chk("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
    chk("rst_mem_wdata", 32'(MEM_WDATA), 32'd0);

    // Release: 50-cycle CLK0 period, core reset after the 16th rise, no requests.
    RESET = 1'b0;
    t = 0; rises = 0; r1 = 0; r2 = 0; last_rise = 0; req_early = 0;
    pc = 1'b0; got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge CORE_CLK);
      t++;
      if (CLK0 && !pc) begin
        rises++;
        if (rises == 1) r1 = t;
        if (rises == 2) r2 = t;
        last_rise = t;
      end
      pc = CLK0;
      if (MEM_REQ) req_early++;
      if (CPU_RESET_n) got = 1'b1;
    end
    chk("cpu_reset_released", 32'(got), 32'd1);
    chk("first_rise_cycle", 32'(r1), 32'd25);
    chk("clk0_period", 32'(r2 - r1), 32'd50);
    chk("rises_before_release", 32'(rises), 32'd16);
    chk("release_after_rise", 32'(t - last_rise), 32'd1);
    chk("no_req_in_reset", 32'(req_early), 32'd0);

    prev_clk0 = CLK0;
    prev_req = MEM_REQ;
    mon_en = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      wait_fall(300);
      CPU_A = vecs[i].addr;
      CPU_RDWR_n = ~vecs[i].we;
      CPU_SYNC = vecs[i].fetch;
      CPU_D_OUT = vecs[i].wdata;
      exp_q.push_back(vecs[i]);
      resp_q.push_back(vecs[i]);
    end

    // Reset while the last request is outstanding.
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CORE_CLK);
      if (MEM_REQ) seen = 1'b1;
    end
    chk("victim_req_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge CORE_CLK);
    #2;
    mon_en = 1'b0;
    RESET = 1'b1;
    #1;
    chk("midreq_mem_req", 32'(MEM_REQ), 32'd0);
    chk("midreq_clk0", 32'(CLK0), 32'd0);
    chk("midreq_cpu_reset_n", 32'(CPU_RESET_n), 32'd0);
    chk("midreq_d_oe", 32'(CPU_D_OE), 32'd0);
    repeat (3) @(negedge CORE_CLK);
    RESET = 1'b0;
    req_hi = 0;
    oe_on = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CORE_CLK);
      if (MEM_REQ) req_hi++;
      if (CPU_D_OE) oe_on++;
    end
    chk("late_ack_no_req", 32'(req_hi), 32'd0);
    chk("late_ack_no_oe", 32'(oe_on), 32'd0);
    chk("late_ack_d_in", 32'(CPU_D_IN), 32'd0);
    chk("late_ack_core_in_reset", 32'(CPU_RESET_n), 32'd0);
    chk("all_expected_consumed", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
